// File: rtl/branch_predictor_pkg.sv
// branch_predictor_pkg: prediction codes, counter states and branch opcode shared with the PC mux.
package branch_predictor_pkg;
  localparam logic [1:0] PRED_NONE = 2'b00;
  localparam logic [1:0] PRED_NT   = 2'b01;
  localparam logic [1:0] PRED_T    = 2'b10;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  typedef enum logic [1:0] {
    CNT_SNT = 2'b00,
    CNT_WNT = 2'b01,
    CNT_WT  = 2'b10,
    CNT_ST  = 2'b11
  } cnt_t;
endpackage

// File: rtl/branch_predictor_sat_counter.sv
// bp_sat_counter: combinational 2-bit saturating counter next-state.
module bp_sat_counter
  import branch_predictor_pkg::*;
(
  input  logic [1:0] cnt,
  input  logic       taken,
  output logic [1:0] nxt
);
  assign nxt = taken ? (cnt == CNT_ST ? cnt : cnt + 2'd1)
                     : (cnt == CNT_SNT ? cnt : cnt - 2'd1);
endmodule

// File: rtl/branch_predictor.sv
// branch_predictor: 2-bit counter table with forwarded single-entry pending update.
// Define BP_STATS_EN to build the resolved-branch / miss statistics counters.
module branch_predictor
  import branch_predictor_pkg::*;
#(
  parameter int         ENTRIES  = 64,
  parameter int         INDEX_W  = $clog2(ENTRIES),
  parameter logic [1:0] INIT_CNT = 2'b01
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] fetch_pc,
  input  logic [31:0] fetch_inst,
  output logic [1:0]  predict_o,
  input  logic        ex_valid,
  input  logic        ex_is_branch,
  input  logic [31:0] ex_pc,
  input  logic        ex_taken,
  input  logic        ex_pred_taken,
  output logic        ex_mispredict_o,
  input  logic        stats_clr,
  output logic [31:0] stat_branches_o,
  output logic [31:0] stat_misses_o
);
  logic [1:0]         cnt_tab [ENTRIES];
  logic               pend_valid;
  logic [INDEX_W-1:0] pend_idx;
  logic [1:0]         pend_cnt;
  logic [INDEX_W-1:0] f_idx, e_idx;
  logic [1:0]         f_cnt, e_cnt, e_nxt;
  logic               resolve;
  logic               unused_ok;
  assign f_idx   = fetch_pc[INDEX_W+1:2];
  assign e_idx   = ex_pc[INDEX_W+1:2];
  assign resolve = ex_valid & ex_is_branch;
  // Pending update is not yet in the table, so both read ports forward it.
  assign f_cnt = (pend_valid && pend_idx == f_idx) ? pend_cnt : cnt_tab[f_idx];
  assign e_cnt = (pend_valid && pend_idx == e_idx) ? pend_cnt : cnt_tab[e_idx];
  assign predict_o = fetch_inst[6:0] == OPC_BRANCH ? (f_cnt[1] ? PRED_T : PRED_NT) : PRED_NONE;
  assign ex_mispredict_o = resolve & (ex_taken != ex_pred_taken);
  assign unused_ok = ^{fetch_inst[31:7], fetch_pc[31:INDEX_W+2], fetch_pc[1:0],
                       ex_pc[31:INDEX_W+2], ex_pc[1:0]};
  bp_sat_counter u_sat (
    .cnt  (e_cnt),
    .taken(ex_taken),
    .nxt  (e_nxt)
  );
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < ENTRIES; i++) cnt_tab[i] <= INIT_CNT;
      pend_valid <= 1'b0;
      pend_idx   <= '0;
      pend_cnt   <= INIT_CNT;
    end else begin
      if (pend_valid) cnt_tab[pend_idx] <= pend_cnt;
      pend_valid <= resolve;
      if (resolve) begin
        pend_idx <= e_idx;
        pend_cnt <= e_nxt;
      end
    end
  end
`ifdef BP_STATS_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stat_branches_o <= '0;
      stat_misses_o   <= '0;
    end else if (stats_clr) begin
      stat_branches_o <= '0;
      stat_misses_o   <= '0;
    end else begin
      if (resolve) stat_branches_o <= stat_branches_o + 32'd1;
      if (ex_mispredict_o) stat_misses_o <= stat_misses_o + 32'd1;
    end
  end
`else
  logic unused_clr;
  assign unused_clr      = stats_clr;
  assign stat_branches_o = '0;
  assign stat_misses_o   = '0;
`endif
endmodule
